seq_mult_16bit: RTL and testbench

//  Unsigned 16x16 -> 32-bit shift-add multiplier driving our external 16-bit CLA adder.

---
 rtl/seq_mult_16bit_if.sv | 49 ++++
 rtl/seq_mult_16bit.sv | 162 ++++++++++++++++
 tb/tb_seq_mult_16bit.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_16bit_if.sv
// ----------------------------------------------------------------------------
// seq_mult_16bit_if
// Bundles the operand/result handshake of seq_mult_16bit together with the
// port to the external 16-bit CLA adder.
//
// Signals
//   start      request, sampled only while the multiplier is idle
//   a, b       multiplicand / multiplier, captured together with start
//   busy       high while iterations are running
//   done       one-cycle pulse, product valid and stable
//   product    32-bit result register, held until the next completion
//   add_a      adder operand A (high accumulator)
//   add_b      adder operand B (multiplicand or zero)
//   add_cin    adder carry-in (always 0)
//   add_sum    adder sum, combinational from add_a/add_b/add_cin
//   state_dbg  encoded FSM state (0 idle, 1 busy, 2 done) for observation
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// multiplier is idle (busy=0, done=0); start is ignored at any other time and
// is never queued. The result is presented by a single-cycle done pulse, and
// product stays valid from that cycle until the next done.
//
// Modports
//   slave   the multiplier's view
//   master  the environment's view (operand source, result sink and adder)
// ----------------------------------------------------------------------------
interface seq_mult_16bit_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic [1:0]  state_dbg;

  modport slave (
    input  start, a, b, add_sum,
    output busy, done, product, add_a, add_b, add_cin, state_dbg
  );

  modport master (
    output start, a, b, add_sum,
    input  busy, done, product, add_a, add_b, add_cin, state_dbg
  );
endinterface

// File: rtl/seq_mult_16bit.sv
// ----------------------------------------------------------------------------
// seq_mult_16bit
// Unsigned 16x16 -> 32-bit shift-add multiplier. The additions are done by an
// external 16-bit CLA adder: every busy cycle the high accumulator and the
// (conditionally selected) multiplicand go out on add_a/add_b, the sum comes
// back on add_sum, and {carry, sum, low} is shifted right by one bit.
// The adder reports only its sum, so the carry-out is rebuilt from the
// operand MSBs and the sum MSB.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   slave modport of seq_mult_16bit_if:
//           start/a/b in, busy/done/product out,
//           add_a/add_b/add_cin out, add_sum in, state_dbg out
//
// Parameters
//   WIDTH  operand width; must equal the adder width (only 16 is supported)
//
// Configuration
//   ZERO_SKIP_EN  when defined, a request with a zero operand goes straight
//                 to the done state with product 0 and never enters busy.
//                 When undefined, zero operands run the full 16 iterations.
//
// Timing
//   start sampled at edge k -> busy for 16 cycles -> done in the cycle after
//   edge k+16 -> idle again. One multiply per 18 cycles back to back.
// ----------------------------------------------------------------------------
module seq_mult_16bit #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_16bit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                 state_q,   state_d;
  logic [WIDTH-1:0]       m_q,       m_d;       // multiplicand
  logic [WIDTH-1:0]       h_q,       h_d;       // high accumulator
  logic [WIDTH-1:0]       l_q,       l_d;       // multiplier / low product
  logic [3:0]             cnt_q,     cnt_d;     // iteration counter
  logic [2*WIDTH-1:0]     product_q, product_d; // result register

  // --------------------------------------------------------------------------
  // Datapath around the external adder
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       add_a_w;
  logic [WIDTH-1:0]       add_b_w;
  logic [WIDTH-1:0]       sum_w;
  logic                   carry_w;
  logic [2*WIDTH-1:0]     shifted_w;

  always_comb begin
    add_a_w = h_q;
    // The multiplicand is added only when the current multiplier bit is set.
    add_b_w = l_q[0] ? m_q : '0;
    sum_w   = bus.add_sum;
    // Carry-out rebuilt from MSBs: both operand MSBs set always carries; with
    // exactly one set, a carry happened iff it did not survive into sum MSB.
    // add_cin is 0, so this is exact.
    carry_w = (add_a_w[WIDTH-1] & add_b_w[WIDTH-1]) |
              ((add_a_w[WIDTH-1] ^ add_b_w[WIDTH-1]) & ~sum_w[WIDTH-1]);
    // One shift-add step: the carry becomes the new MSB of the high half and
    // the sum LSB drops into the top of the low half.
    shifted_w = {carry_w, sum_w, l_q[WIDTH-1:1]};
  end

  // --------------------------------------------------------------------------
  // Next-state and register updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    h_d       = h_q;
    l_d       = l_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef ZERO_SKIP_EN
          if ((bus.a == '0) || (bus.b == '0)) begin
            // Result is known to be zero; skip the iterations entirely.
            state_d   = ST_DONE;
            product_d = '0;
          end else begin
            m_d     = bus.a;
            l_d     = bus.b;
            h_d     = '0;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
`else
          m_d     = bus.a;
          l_d     = bus.b;
          h_d     = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
`endif
        end
      end

      ST_BUSY: begin
        {h_d, l_d} = shifted_w;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Last iteration: the shifted value is the complete product.
          state_d   = ST_DONE;
          product_d = shifted_w;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      h_q       <= '0;
      l_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      h_q       <= h_d;
      l_q       <= l_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: status is decoded straight from the state register.
  // --------------------------------------------------------------------------
  assign bus.busy      = (state_q == ST_BUSY);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.product   = product_q;
  assign bus.add_a     = add_a_w;
  assign bus.add_b     = add_b_w;
  assign bus.add_cin   = 1'b0;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seq_mult_16bit.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_16bit
// Directed and random checks of seq_mult_16bit. The external CLA adder is
// modelled here as a plain 16-bit combinational add.
// ----------------------------------------------------------------------------
module tb_seq_mult_16bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_mult_16bit_if bus ();

  seq_mult_16bit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External adder model.
  assign bus.add_sum = bus.add_a + bus.add_b + {15'd0, bus.add_cin};

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Driver: launch one multiply and follow it to completion.
  // Outputs: product seen with done, edges from start sample to done,
  // number of busy cycles, done pulse width (1 or 2+), timeout flag.
  // --------------------------------------------------------------------------
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat,
                         output int nbusy, output int dwidth,
                         output bit timeout);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat     = 0;
    nbusy   = 0;
    timeout = 1'b0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) timeout = 1'b1;
    p = bus.product;
    @(posedge clk); #1;
    dwidth = bus.done ? 2 : 1;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset;
    logic [31:0] p;
    int lat, nb, dw;
    bit to;
    // Out of power-on reset.
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0 ||
        bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_initial: busy=%b done=%b product=%h state=%0d, expected 0 0 00000000 0",
               bus.busy, bus.done, bus.product, bus.state_dbg);
    end
    // Make product nonzero, then reset in the middle of a second multiply.
    do_mult(16'h0011, 16'h0022, p, lat, nb, dw, to);
    checks++;
    if (p !== 32'h0000_0242) begin
      errors++;
      $display("FAIL reset_premult: product=%h expected 00000242", p);
    end
    bus.start = 1'b1; bus.a = 16'hBEEF; bus.b = 16'h1357;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0 ||
        bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b product=%h state=%0d, expected 0 0 00000000 0",
               bus.busy, bus.done, bus.product, bus.state_dbg);
    end
  endtask

  task automatic test_basic;
    logic [31:0] p;
    int lat, nb, dw;
    bit to;
    do_mult(16'd3, 16'd5, p, lat, nb, dw, to);
    checks++;
    if (to || lat !== 16) begin
      errors++;
      $display("FAIL basic_latency: timeout=%0d latency=%0d expected 16", to, lat);
    end
    checks++;
    if (nb !== 16) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 16", nb);
    end
    checks++;
    if (p !== 32'h0000_000F) begin
      errors++;
      $display("FAIL basic_product: got %h expected 0000000F", p);
    end
    checks++;
    if (dw !== 1) begin
      errors++;
      $display("FAIL basic_done_width: got %0d expected 1", dw);
    end
    // Product is held after completion.
    @(posedge clk); #1;
    checks++;
    if (bus.product !== 32'h0000_000F) begin
      errors++;
      $display("FAIL basic_product_hold: got %h expected 0000000F", bus.product);
    end
  endtask

  task automatic test_max_carry;
    logic [16:0] s17;
    logic        prev_c;
    int          i;
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    prev_c = 1'b0;
    for (i = 0; i < 16; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.add_b !== 16'hFFFF) begin
        errors++;
        $display("FAIL max_add_b[%0d]: busy=%b add_b=%h expected 1 FFFF", i, bus.busy, bus.add_b);
      end
      // The carry of the previous step must reappear as the MSB of add_a.
      if (i > 0) begin
        checks++;
        if (bus.add_a[15] !== prev_c) begin
          errors++;
          $display("FAIL max_carry[%0d]: add_a[15]=%b expected %b", i, bus.add_a[15], prev_c);
        end
      end
      s17    = {1'b0, bus.add_a} + {1'b0, bus.add_b};
      prev_c = s17[16];
      checks++;
      if (prev_c !== (i > 0)) begin
        errors++;
        $display("FAIL max_carry_ref[%0d]: carry=%b expected %b", i, prev_c, (i > 0));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 32'hFFFE_0001) begin
      errors++;
      $display("FAIL max_product: done=%b product=%h expected 1 FFFE0001", bus.done, bus.product);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int lat;
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      // Pulse start with different operands at edge k+5.
      bus.start = (lat == 4);
      if (lat == 4) begin bus.a = 16'd1; bus.b = 16'd1; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    checks++;
    if (!bus.done || lat !== 16 || bus.product !== 32'h0626_0060) begin
      errors++;
      $display("FAIL start_ignored: done=%b latency=%0d product=%h expected 1 16 06260060",
               bus.done, lat, bus.product);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL start_ignored_idle: state=%0d expected 0", bus.state_dbg);
    end
  endtask

  task automatic test_abort_restart;
    logic [31:0] p;
    int lat, nb, dw, seen;
    bit to;
    bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0101;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0 || bus.product !== 32'h0) begin
      errors++;
      $display("FAIL abort: busy/done cycles=%0d product=%h expected 0 00000000", seen, bus.product);
    end
    do_mult(16'd2, 16'd7, p, lat, nb, dw, to);
    checks++;
    if (to || lat !== 16 || p !== 32'd14) begin
      errors++;
      $display("FAIL restart: timeout=%0d latency=%0d product=%h expected 0 16 0000000E", to, lat, p);
    end
  endtask

  task automatic test_zero_operand;
    logic [31:0] p;
    int lat, nb, dw, exp_lat;
    bit to;
`ifdef ZERO_SKIP_EN
    exp_lat = 0;
`else
    exp_lat = 16;
`endif
    do_mult(16'h1234, 16'h0000, p, lat, nb, dw, to);
    checks++;
    if (to || lat !== exp_lat || nb !== exp_lat || p !== 32'h0 || dw !== 1) begin
      errors++;
      $display("FAIL zero_b: timeout=%0d latency=%0d busy=%0d product=%h width=%0d expected 0 %0d %0d 00000000 1",
               to, lat, nb, p, dw, exp_lat, exp_lat);
    end
    do_mult(16'h0000, 16'hABCD, p, lat, nb, dw, to);
    checks++;
    if (to || lat !== exp_lat || nb !== exp_lat || p !== 32'h0 || dw !== 1) begin
      errors++;
      $display("FAIL zero_a: timeout=%0d latency=%0d busy=%0d product=%h width=%0d expected 0 %0d %0d 00000000 1",
               to, lat, nb, p, dw, exp_lat, exp_lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic [31:0] p, e;
    logic [15:0] ra, rb;
    int lat, nb, dw, exp_lat;
    bit to;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (n % 50 == 7) ra = 16'h0000;
      exp_q.push_back({16'h0, ra} * {16'h0, rb});
`ifdef ZERO_SKIP_EN
      exp_lat = (ra == 16'h0 || rb == 16'h0) ? 0 : 16;
`else
      exp_lat = 16;
`endif
      do_mult(ra, rb, p, lat, nb, dw, to);
      e = exp_q.pop_front();
      checks++;
      if (to || p !== e || lat !== exp_lat || dw !== 1) begin
        errors++;
        $display("FAIL random[%0d] %h*%h: product=%h latency=%0d width=%0d timeout=%0d expected %h %0d 1 0",
                 n, ra, rb, p, lat, dw, to, e, exp_lat);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_basic();
    test_max_carry();
    test_start_ignored();
    test_abort_restart();
    test_zero_operand();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
